mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Bus responder for the 8-bit CPU's single-master memory bus (addr/data-in/data-out/we). It provides a byte RAM, a small memory-mapped I/O window, and a boot loader. The loader streams a program into RAM over a valid/ready byte interface while holding the CPU in reset. Read data is registered with one-cycle latency, so the CPU's fetch sequence captures mem[addr] one edge after presenting addr.

Parameters:
DEPTH_LOG2  12       RAM size = 2**DEPTH_LOG2 bytes, mapped at 0x0000
IO_BASE     16'hFF00 base of the 4-byte I/O window (low 2 bits of IO_BASE are 0)

Ports:
clk        in   1   clock
rst        in   1   reset, asynchronous, active-high
addr       in   16  CPU bus address
wdata      in   8   CPU write data (CPU do)
we         in   1   CPU write strobe, sampled at posedge
rdata      out  8   read data to CPU (CPU di), registered
ld_valid   in   1   loader byte valid
ld_data    in   8   loader byte
ld_last    in   1   final loader byte, qualified by ld_valid
ld_ready   out  1   loader byte accepted when ld_valid and ld_ready are both high at posedge
reload     in   1   one-cycle pulse; re-enters load mode
cpu_rst    out  1   reset for the CPU, high while loading
io_out     out  8   general-purpose output register

Behaviour:
- Reset values: rdata=0, io_out=0, load pointer=0, overflow=0, timer=0, state=S_LOAD.
- RAM contents are not cleared by reset.
- State machine, two states:
  - S_LOAD: cpu_rst=1; ld_ready = !rst.
    - Each accepted beat writes ld_data to RAM[ptr], then ptr++.
    - Accepted beat with ld_last=1 -> S_RUN on the same edge; ptr returns to 0.
    - ptr wraps from 2**DEPTH_LOG2-1 to 0 and sets overflow (sticky until reset or reload).
    - CPU writes are ignored; rdata is held at 0.
  - S_RUN: cpu_rst=0; ld_ready=0; CPU bus is serviced.
    - reload=1 -> S_LOAD, ptr=0, overflow=0.
    - reload takes priority over a simultaneous CPU we: the write is dropped.
- cpu_rst and ld_ready are combinational from state (no extra latency), so cpu_rst deasserts in the first S_RUN cycle.
- CPU reads (S_RUN): every posedge, rdata <= decode(addr).
  - addr < 2**DEPTH_LOG2: RAM[addr].
  - IO_BASE+0: io_out.
  - IO_BASE+1: timer.
  - IO_BASE+2: status = {6'b0, running, overflow}.
  - IO_BASE+3 and all other addresses: 0x00.
- CPU writes (S_RUN, we=1 at posedge):
  - RAM range: RAM[addr] <= wdata.
  - IO_BASE+0: io_out <= wdata.
  - IO_BASE+1: timer <= 0.
  - All other addresses: dropped.
- Read-during-write to the same RAM address returns the old data (read-first).
- Reset mid-load: state returns to S_LOAD with ptr=0. A partially loaded image stays in RAM and is overwritten by the next load.
- ld_valid without ld_ready (in S_RUN) has no effect. ld_last without ld_valid is ignored.

Optional Feature:
- Macro MEM_RESPONDER_TIMER_EN.
- Defined: 8-bit timer increments every clk in S_RUN, wraps 0xFF->0x00, holds in S_LOAD, and is cleared by a write to IO_BASE+1.
- Undefined: no timer register; IO_BASE+1 reads 0x00 and writes to it are dropped.

Decomposition:
- Package mem_responder_pkg holds:
  - state encoding S_LOAD/S_RUN
  - I/O offsets IO_OUT=0, IO_TIMER=1, IO_STATUS=2
  - status bit indices OVF=0, RUN=1
- Sub-module mem_responder_ram: single-port synchronous byte RAM with registered read-first output, parameterised by DEPTH_LOG2.
- The top level muxes the port between loader (S_LOAD) and CPU (S_RUN).

Test Plan:
1. Reset, stream bytes 0x11,0x22,0x33,0x44 with ld_last on 0x44 -> cpu_rst falls the edge after the last beat; reads of addr 0..3 return 0x11..0x44 one cycle after addr is presented.
2. S_RUN: write 0x5A to 0x0010, read 0x0010 -> 0x5A; write 0xA5 to 0xFF00 -> io_out=0xA5 and read back 0xA5; write to 0x8000 -> dropped, reads 0x00.
3. Load 2**DEPTH_LOG2+1 bytes with ld_last on the final one -> RAM[0] holds the final byte; status reads 0x03.
4. In S_RUN, pulse reload together with we to 0x0000 -> write dropped, cpu_rst=1, ld_ready=1, ptr=0, status bit0=0.
5. Assert rst after 3 accepted beats, then load 0xEE with ld_last -> RAM[0]=0xEE, RAM[1..2] keep the earlier bytes.
6. With MEM_RESPONDER_TIMER_EN: write 0xFF01, wait 10 cycles -> read 0x0A (±1 per register latency); 256 cycles later it has wrapped. Without the macro: read 0x00.

Source files
------------

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_pkg
// Purpose  : Shared constants for the memory responder: state encoding,
//            I/O window register offsets and status-register bit positions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    // Controller state encoding
    localparam int             STATE_W = 1;
    localparam logic [STATE_W-1:0] S_LOAD  = 1'b0;
    localparam logic [STATE_W-1:0] S_RUN   = 1'b1;

    // Register offsets inside the 4-byte I/O window
    localparam logic [1:0] IO_OUT    = 2'd0;
    localparam logic [1:0] IO_TIMER  = 2'd1;
    localparam logic [1:0] IO_STATUS = 2'd2;

    // Bit positions inside the status register
    localparam int OVF = 0;
    localparam int RUN = 1;

    // Assemble the status byte from its individual flags.
    function automatic logic [7:0] status_byte(input logic running, input logic overflow);
        logic [7:0] v;
        v      = 8'h00;
        v[RUN] = running;
        v[OVF] = overflow;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_ram
// Purpose  : Single-port synchronous byte RAM with a registered, read-first
//            output (a read that coincides with a write returns old data).
//            Contents are never reset.
// Ports    : clk      - clock
//            i_we     - write enable
//            i_addr   - byte address
//            i_wdata  - write data
//            o_rdata  - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder_ram
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [7:0]            i_wdata,
    output logic [7:0]            o_rdata
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [7:0] r_mem [0:c_DEPTH-1];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Bus responder for the 8-bit CPU. Provides a byte RAM at 0x0000,
//            a 4-byte I/O window at IO_BASE and a streaming boot loader that
//            fills RAM while holding the CPU in reset.
//            Optional free-running timer enabled by MEM_RESPONDER_TIMER_EN.
// Ports    : clk      - clock
//            rst      - asynchronous active-high reset
//            addr     - CPU address
//            wdata    - CPU write data
//            we       - CPU write strobe
//            rdata    - registered read data (one-cycle latency)
//            ld_valid - loader byte valid
//            ld_data  - loader byte
//            ld_last  - final loader byte
//            ld_ready - loader byte accept
//            reload   - pulse to re-enter load mode
//            cpu_rst  - CPU reset, high while loading
//            io_out   - general-purpose output register
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [15:0] IO_BASE    = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic        reload,
    output logic        cpu_rst,
    output logic [7:0]  io_out
);

    localparam logic [16:0] c_RAM_BYTES = 17'(1) << DEPTH_LOG2;

    logic [STATE_W-1:0]    r_state;
    logic [DEPTH_LOG2-1:0] r_ptr;
    logic                  r_ovf;
    logic [7:0]            r_io_out;
    logic                  r_sel_ram;
    logic [7:0]            r_io_rdata;

    logic                  w_loading;
    logic                  w_ld_accept;
    logic                  w_in_ram;
    logic                  w_in_io;
    logic                  w_cpu_we;
    logic                  w_ram_we;
    logic [DEPTH_LOG2-1:0] w_ram_addr;
    logic [7:0]            w_ram_wdata;
    logic [7:0]            w_ram_q;
    logic [7:0]            w_io_rdata;
    logic [7:0]            w_timer;

    assign w_loading   = (r_state == S_LOAD);
    assign ld_ready    = w_loading & ~rst;
    assign cpu_rst     = w_loading;
    assign w_ld_accept = ld_valid & ld_ready;

    assign w_in_ram = ({1'b0, addr} < c_RAM_BYTES);
    assign w_in_io  = (addr[15:2] == IO_BASE[15:2]);
    // A simultaneous reload wins over a CPU write.
    assign w_cpu_we = ~w_loading & we & ~reload;

    // The single RAM port belongs to the loader while loading, else the CPU.
    assign w_ram_we    = w_loading ? w_ld_accept : (w_cpu_we & w_in_ram);
    assign w_ram_addr  = w_loading ? r_ptr : addr[DEPTH_LOG2-1:0];
    assign w_ram_wdata = w_loading ? ld_data : wdata;

    mem_responder_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    always_comb begin
        w_io_rdata = 8'h00;
        if (w_in_io) begin
            case (addr[1:0])
                IO_OUT:    w_io_rdata = r_io_out;
                IO_TIMER:  w_io_rdata = w_timer;
                IO_STATUS: w_io_rdata = status_byte(~w_loading, r_ovf);
                default:   w_io_rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_LOAD;
            r_ptr      <= '0;
            r_ovf      <= 1'b0;
            r_io_out   <= 8'h00;
            r_sel_ram  <= 1'b0;
            r_io_rdata <= 8'h00;
        end else if (w_loading) begin
            // Read data is forced to zero while the CPU is held in reset.
            r_sel_ram  <= 1'b0;
            r_io_rdata <= 8'h00;
            if (w_ld_accept) begin
                if (ld_last) begin
                    r_state <= S_RUN;
                    r_ptr   <= '0;
                end else begin
                    r_ptr <= r_ptr + DEPTH_LOG2'(1);
                    // An image that fills RAM exactly is not an overflow;
                    // only wrapping with more bytes to come is.
                    if (r_ptr == '1) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end else begin
            // The registered select plus the RAM's own output register
            // together give one-cycle read latency for every address.
            r_sel_ram  <= w_in_ram;
            r_io_rdata <= w_io_rdata;
            if (reload) begin
                r_state <= S_LOAD;
                r_ptr   <= '0;
                r_ovf   <= 1'b0;
            end else if (w_cpu_we && w_in_io && (addr[1:0] == IO_OUT)) begin
                r_io_out <= wdata;
            end
        end
    end

`ifdef MEM_RESPONDER_TIMER_EN
    logic [7:0] r_timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= 8'h00;
        end else if (!w_loading) begin
            if (w_cpu_we && w_in_io && (addr[1:0] == IO_TIMER)) begin
                r_timer <= 8'h00;
            end else begin
                r_timer <= r_timer + 8'd1;
            end
        end
    end

    assign w_timer = r_timer;
`else
    assign w_timer = 8'h00;
`endif

    assign rdata  = r_sel_ram ? w_ram_q : r_io_rdata;
    assign io_out = r_io_out;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder: boot load, CPU RAM/I-O
//            access table, loader overflow, reload priority, reset mid-load
//            and the optional timer (MEM_RESPONDER_TIMER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        reload;
    logic        cpu_rst;
    logic [7:0]  io_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [21];

    logic [7:0]  sb_exp  [$];
    logic [15:0] sb_addr [$];

    mem_responder dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .rdata    (rdata),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .reload   (reload),
        .cpu_rst  (cpu_rst),
        .io_out   (io_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One CPU bus cycle. Expected read data is queued when the address is
    // driven and compared once the DUT's registered output has updated.
    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic w,
                       input logic chk, input logic [7:0] e);
        logic [7:0]  ex;
        logic [15:0] ea;
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = w;
        if (chk) begin
            sb_exp.push_back(e);
            sb_addr.push_back(a);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        if (sb_exp.size() != 0) begin
            ex = sb_exp.pop_front();
            ea = sb_addr.pop_front();
            check($sformatf("rdata@%h", ea), rdata, ex);
        end
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e);
        bus(a, 8'h00, 1'b0, 1'b1, e);
    endtask

    task automatic idle();
        bus(16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic ld_beat(input logic [7:0] d, input logic last);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    function automatic logic [7:0] img(input int i);
        return 8'(i * 7 + 3);
    endfunction

    initial begin
        vecs[0]  = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h11};
        vecs[1]  = '{16'h0001, 8'h00, 1'b0, 1'b1, 8'h22};
        vecs[2]  = '{16'h0002, 8'h00, 1'b0, 1'b1, 8'h33};
        vecs[3]  = '{16'h0003, 8'h00, 1'b0, 1'b1, 8'h44};
        vecs[4]  = '{16'h0010, 8'h5A, 1'b1, 1'b0, 8'h00};
        vecs[5]  = '{16'h0010, 8'h00, 1'b0, 1'b1, 8'h5A};
        vecs[6]  = '{16'h0011, 8'h66, 1'b1, 1'b0, 8'h00};
        vecs[7]  = '{16'h0011, 8'h99, 1'b1, 1'b1, 8'h66};  // read-first
        vecs[8]  = '{16'h0011, 8'h00, 1'b0, 1'b1, 8'h99};
        vecs[9]  = '{16'hFF00, 8'hA5, 1'b1, 1'b1, 8'h00};  // old io_out
        vecs[10] = '{16'hFF00, 8'h00, 1'b0, 1'b1, 8'hA5};
        vecs[11] = '{16'h8000, 8'h77, 1'b1, 1'b1, 8'h00};
        vecs[12] = '{16'h8000, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[13] = '{16'hFF02, 8'hFF, 1'b1, 1'b1, 8'h02};
        vecs[14] = '{16'hFF02, 8'h00, 1'b0, 1'b1, 8'h02};
        vecs[15] = '{16'hFF03, 8'h55, 1'b1, 1'b1, 8'h00};
        vecs[16] = '{16'hFF03, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[17] = '{16'h0FFF, 8'hC3, 1'b1, 1'b0, 8'h00};
        vecs[18] = '{16'h0FFF, 8'h00, 1'b0, 1'b1, 8'hC3};
        vecs[19] = '{16'h1000, 8'h12, 1'b1, 1'b1, 8'h00};  // just past RAM
        vecs[20] = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h11};  // no alias write

        rst      = 1'b1;
        addr     = 16'h0000;
        wdata    = 8'h00;
        we       = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        ld_last  = 1'b0;
        reload   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset rdata", rdata, 8'h00);
        check("reset io_out", io_out, 8'h00);
        check("reset cpu_rst", {7'b0, cpu_rst}, 8'h01);
        check("ld_ready in rst", {7'b0, ld_ready}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ld_ready after rst", {7'b0, ld_ready}, 8'h01);

        // Boot load of a 4-byte image
        ld_beat(8'h11, 1'b0);
        ld_beat(8'h22, 1'b0);
        ld_beat(8'h33, 1'b0);
        check("cpu_rst mid-load", {7'b0, cpu_rst}, 8'h01);
        check("rdata held in load", rdata, 8'h00);
        ld_beat(8'h44, 1'b1);
        check("cpu_rst after last", {7'b0, cpu_rst}, 8'h00);
        check("ld_ready in run", {7'b0, ld_ready}, 8'h00);

        // CPU access table
        for (int i = 0; i < 21; i++) begin
            bus(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].chk, vecs[i].exp);
        end
        check("io_out after write", io_out, 8'hA5);

        // Loader handshake is ignored while running
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = 8'h99;
        ld_last  = 1'b1;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("cpu_rst ld in run", {7'b0, cpu_rst}, 8'h00);
        rd(16'h0000, 8'h11);

        // Overflowing load: 2**12 + 1 bytes
        pulse_reload();
        check("cpu_rst after reload", {7'b0, cpu_rst}, 8'h01);
        for (int i = 0; i <= 4096; i++) begin
            ld_beat(img(i), (i == 4096));
        end
        check("cpu_rst after ovf load", {7'b0, cpu_rst}, 8'h00);
        rd(16'h0000, img(4096));
        rd(16'h0001, img(1));
        rd(16'h0FFF, img(4095));
        rd(16'hFF02, 8'h03);

        // Reload beats a simultaneous CPU write
        @(negedge clk);
        addr   = 16'h0003;
        wdata  = 8'hBD;
        we     = 1'b1;
        reload = 1'b1;
        @(posedge clk);
        #1;
        we     = 1'b0;
        reload = 1'b0;
        check("cpu_rst reload+we", {7'b0, cpu_rst}, 8'h01);
        check("ld_ready reload+we", {7'b0, ld_ready}, 8'h01);
        ld_beat(8'h61, 1'b0);
        ld_beat(8'h62, 1'b1);
        rd(16'h0000, 8'h61);
        rd(16'h0001, 8'h62);
        rd(16'h0003, img(3));
        rd(16'hFF02, 8'h02);

        // Reset in the middle of a load
        pulse_reload();
        ld_beat(8'hA1, 1'b0);
        ld_beat(8'hA2, 1'b0);
        ld_beat(8'hA3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("cpu_rst in mid rst", {7'b0, cpu_rst}, 8'h01);
        check("ld_ready in mid rst", {7'b0, ld_ready}, 8'h00);
        check("io_out cleared", io_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ld_last = 1'b1;
        @(posedge clk);
        #1;
        ld_last = 1'b0;
        check("ld_last w/o valid", {7'b0, cpu_rst}, 8'h01);
        ld_beat(8'hEE, 1'b1);
        rd(16'h0000, 8'hEE);
        rd(16'h0001, 8'hA2);
        rd(16'h0002, 8'hA3);
        rd(16'h0003, img(3));

        // Timer register
`ifdef MEM_RESPONDER_TIMER_EN
        bus(16'hFF01, 8'h00, 1'b1, 1'b0, 8'h00);
        repeat (10) idle();
        rd(16'hFF01, 8'h0A);
        repeat (255) idle();
        rd(16'hFF01, 8'h0A);
`else
        bus(16'hFF01, 8'h00, 1'b1, 1'b0, 8'h00);
        repeat (10) idle();
        rd(16'hFF01, 8'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
